// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: bus width, FSM states, timeout default.
// WIDTH is a project-wide macro so every file agrees on the shared-port width.
`ifndef WIDTH
`define WIDTH 64
`endif

package mem_port_arbiter_pkg;

  localparam int unsigned MEM_W           = `WIDTH;
  localparam int unsigned MEM_BE_W        = `WIDTH / 8;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_t;

  // Command captured at grant time; the shared port is driven only from this.
  typedef struct packed {
    logic                we;
    logic [MEM_W-1:0]    addr;
    logic [MEM_W-1:0]    wdata;
    logic [MEM_BE_W-1:0] be;
  } mem_cmd_t;

  function automatic logic [31:0] pick_word(input logic [MEM_W-1:0] rdata, input logic sel_hi);
    return sel_hi ? rdata[63:32] : rdata[31:0];
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Grant watchdog: counts grant cycles without ack; o_expire is combinational in the cycle
// the count would reach LIMIT. Clears on i_clr, holds while i_en is low.
module mem_arb_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [15:0] r_cnt;
  logic [15:0] w_next;

  assign w_next   = r_cnt + 16'd1;
  // LIMIT >= 1 and the FSM leaves the grant on expiry, so the count never wraps.
  assign o_expire = i_en && (32'(w_next) == LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_next;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port; grant 1 cycle after request, wait drops on ack.
// Requesters are held by wait until ack or timeout abort; MEM_ARB_RR_EN selects round-robin over data-first.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                p_clk,
  input  logic                p_rst,
  input  logic                p_IF_INST_MemRead,
  input  logic [`WIDTH-1:0]   p_IF_INST_MemAddress,
  output logic [31:0]         p_IF_INST_MemDataIn,
  output logic                p_IF_INST_MemWait,
  input  logic                p_D_MemRead,
  input  logic                p_D_MemWrite,
  input  logic [`WIDTH-1:0]   p_D_MemAddress,
  input  logic [`WIDTH-1:0]   p_D_MemWriteData,
  input  logic [`WIDTH/8-1:0] p_D_MemByteEn,
  output logic [`WIDTH-1:0]   p_D_MemReadData,
  output logic                p_D_MemWait,
  output logic                p_MEM_Req,
  output logic                p_MEM_We,
  output logic [`WIDTH-1:0]   p_MEM_Address,
  output logic [`WIDTH-1:0]   p_MEM_WriteData,
  output logic [`WIDTH/8-1:0] p_MEM_ByteEn,
  input  logic [`WIDTH-1:0]   p_MEM_ReadData,
  input  logic                p_MEM_Ack,
  output logic                p_ARB_Timeout
);

  arb_state_t r_state;
  mem_cmd_t   r_cmd;
  logic       r_mem_req;
  logic       r_timeout;

  logic w_req_d;
  logic w_pick_d;
  logic w_grant;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expire;

  assign w_req_d = p_D_MemRead | p_D_MemWrite;
  assign w_grant = (r_state == ST_IDLE) && (w_req_d || p_IF_INST_MemRead);

`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  // On a conflict, favour whoever was not granted last.
  assign w_pick_d = w_req_d && (!p_IF_INST_MemRead || !r_last_d);

  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      r_last_d <= 1'b1;
    end else if (w_grant) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = w_req_d;
`endif

  assign w_tmr_clr = w_grant;
  assign w_tmr_en  = (r_state != ST_IDLE) && !p_MEM_Ack;

  mem_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (p_clk),
    .i_rst    (p_rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      r_state   <= ST_IDLE;
      r_cmd     <= '0;
      r_mem_req <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_d) begin
            r_state   <= ST_GNT_D;
            r_cmd     <= '{we: p_D_MemWrite, addr: p_D_MemAddress,
                           wdata: p_D_MemWriteData, be: p_D_MemByteEn};
            r_mem_req <= 1'b1;
          end else if (p_IF_INST_MemRead) begin
            r_state   <= ST_GNT_I;
            r_cmd     <= '{we: 1'b0, addr: p_IF_INST_MemAddress, wdata: '0, be: '1};
            r_mem_req <= 1'b1;
          end
        end
        default: begin
          // Ack beats expiry when both land in the same cycle.
          if (p_MEM_Ack || w_expire) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            if (!p_MEM_Ack) begin
              r_timeout <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign p_MEM_Req       = r_mem_req;
  assign p_MEM_We        = r_cmd.we;
  assign p_MEM_Address   = r_cmd.addr;
  assign p_MEM_WriteData = r_cmd.wdata;
  assign p_MEM_ByteEn    = r_cmd.be;
  assign p_ARB_Timeout   = r_timeout;

  assign p_IF_INST_MemWait   = !((r_state == ST_GNT_I) && p_MEM_Ack);
  assign p_D_MemWait         = !((r_state == ST_GNT_D) && p_MEM_Ack);
  assign p_IF_INST_MemDataIn = pick_word(p_MEM_ReadData, r_cmd.addr[2]);
  assign p_D_MemReadData     = p_MEM_ReadData;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT_CYCLES=4); inputs change 1 time unit after
// the rising edge, outputs are checked on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_rd;
  logic [63:0] if_addr;
  logic [31:0] if_data;
  logic        if_wait;
  logic        d_rd, d_wr;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_be;
  logic        d_wait;
  logic        mem_req, mem_we, mem_ack, arb_to;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_be;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .p_clk                (clk),
    .p_rst                (rst),
    .p_IF_INST_MemRead    (if_rd),
    .p_IF_INST_MemAddress (if_addr),
    .p_IF_INST_MemDataIn  (if_data),
    .p_IF_INST_MemWait    (if_wait),
    .p_D_MemRead          (d_rd),
    .p_D_MemWrite         (d_wr),
    .p_D_MemAddress       (d_addr),
    .p_D_MemWriteData     (d_wdata),
    .p_D_MemByteEn        (d_be),
    .p_D_MemReadData      (d_rdata),
    .p_D_MemWait          (d_wait),
    .p_MEM_Req            (mem_req),
    .p_MEM_We             (mem_we),
    .p_MEM_Address        (mem_addr),
    .p_MEM_WriteData      (mem_wdata),
    .p_MEM_ByteEn         (mem_be),
    .p_MEM_ReadData       (mem_rdata),
    .p_MEM_Ack            (mem_ack),
    .p_ARB_Timeout        (arb_to)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Winners of the three conflict grants: 1 = data, 0 = fetch.
`ifdef MEM_ARB_RR_EN
  bit exp_d [3] = '{1'b0, 1'b1, 1'b0};
`else
  bit exp_d [3] = '{1'b1, 1'b1, 1'b0};
`endif

  initial begin
    rst = 1'b1; if_rd = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_ack = 1'b0;
    mem_rdata = 64'h1111_2222_3333_4444;

    // Reset state
    step(); step(); settle();
    chk("rst_req", mem_req, 0);
    chk("rst_if_wait", if_wait, 1);
    chk("rst_d_wait", d_wait, 1);
    chk("rst_timeout", arb_to, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    step(); rst = 1'b0;

    // Ack while idle is ignored
    mem_ack = 1'b1; settle();
    chk("idle_ack_if_wait", if_wait, 1);
    chk("idle_ack_d_wait", d_wait, 1);
    step(); mem_ack = 1'b0; settle();
    chk("idle_ack_req", mem_req, 0);

    // Fetch only, ack one cycle after Req
    step(); if_rd = 1'b1; if_addr = 64'h100; settle();
    chk("f_n_req", mem_req, 0);
    chk("f_n_wait", if_wait, 1);
    step(); mem_ack = 1'b1; settle();
    chk("f_req", mem_req, 1);
    chk("f_addr", mem_addr, 64'h100);
    chk("f_we", mem_we, 0);
    chk("f_be", mem_be, 8'hFF);
    chk("f_wait", if_wait, 0);
    chk("f_data", if_data, 32'h3333_4444);
    chk("f_d_wait", d_wait, 1);
    step(); if_rd = 1'b0; mem_ack = 1'b0; settle();
    chk("f_after_req", mem_req, 0);
    chk("f_after_wait", if_wait, 1);

    // Data read acked in the cycle the timer would expire: completion wins
    step(); d_rd = 1'b1; d_addr = 64'h3000; settle();
    for (int i = 1; i <= 4; i++) begin
      step(); mem_ack = (i == 4); settle();
      chk("race_req", mem_req, 1);
      chk("race_d_wait", d_wait, (i == 4) ? 0 : 1);
    end
    chk("race_rdata", d_rdata, 64'h1111_2222_3333_4444);
    step(); d_rd = 1'b0; mem_ack = 1'b0; settle();
    chk("race_idle", mem_req, 0);
    chk("race_no_timeout", arb_to, 0);

    // Simultaneous fetch 0x104 and data read 0x2000 straight after reset
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    if_rd = 1'b1; if_addr = 64'h104; d_rd = 1'b1; d_addr = 64'h2000; settle();
    chk("cf_idle", mem_req, 0);
    for (int g = 0; g < 3; g++) begin
      step(); mem_ack = 1'b1; settle();
      chk("cf_req", mem_req, 1);
      chk("cf_addr", mem_addr, exp_d[g] ? 64'h2000 : 64'h104);
      chk("cf_if_wait", if_wait, exp_d[g] ? 1 : 0);
      chk("cf_d_wait", d_wait, exp_d[g] ? 0 : 1);
      if (!exp_d[g]) chk("cf_if_data", if_data, 32'h1111_2222);
      step(); mem_ack = 1'b0;
      if (g == 1) d_rd = 1'b0;
      if (g == 2) if_rd = 1'b0;
      settle();
      chk("cf_gap", mem_req, 0);
    end

    // Data write; address changes mid-grant must not reach the port
    step(); d_wr = 1'b1; d_addr = 64'h08; d_wdata = 64'hDEAD_BEEF; d_be = 8'h0F; settle();
    step(); d_addr = 64'h40; settle();
    chk("w_req", mem_req, 1);
    chk("w_we", mem_we, 1);
    chk("w_addr", mem_addr, 64'h08);
    chk("w_wdata", mem_wdata, 64'hDEAD_BEEF);
    chk("w_be", mem_be, 8'h0F);
    chk("w_wait_noack", d_wait, 1);
    step(); mem_ack = 1'b1; settle();
    chk("w_wait_ack", d_wait, 0);
    chk("w_addr_held", mem_addr, 64'h08);
    step(); mem_ack = 1'b0; d_wr = 1'b0; settle();
    chk("w_idle", mem_req, 0);

    // Fetch never acked: abort after 4 grant cycles, then re-issue
    step(); if_rd = 1'b1; if_addr = 64'h200; settle();
    for (int i = 1; i <= 4; i++) begin
      step(); settle();
      chk("to_req", mem_req, 1);
      chk("to_wait", if_wait, 1);
      chk("to_flag_low", arb_to, 0);
    end
    step(); settle();
    chk("to_abort_req", mem_req, 0);
    chk("to_abort_wait", if_wait, 1);
    chk("to_flag", arb_to, 1);
    step(); settle();
    chk("to_reissue_req", mem_req, 1);
    chk("to_reissue_addr", mem_addr, 64'h200);
    step(); mem_ack = 1'b1; settle();
    chk("to_reissue_wait", if_wait, 0);
    step(); mem_ack = 1'b0; if_rd = 1'b0; settle();
    chk("to_sticky", arb_to, 1);

    // Reset while a data grant is in flight
    step(); d_rd = 1'b1; d_addr = 64'h2000; settle();
    step(); settle();
    chk("rg_req", mem_req, 1);
    rst = 1'b1;
    step(); settle();
    chk("rg_req_off", mem_req, 0);
    chk("rg_if_wait", if_wait, 1);
    chk("rg_d_wait", d_wait, 1);
    chk("rg_flag", arb_to, 0);
    step(); rst = 1'b0; d_rd = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
